// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
// Shared types and constants for the board SRAM arbiter.
//   state_t : arbiter FSM states
//   grant_t : which requester was served last (drives round-robin on ties)
//   SRAM_ADDR_W / SRAM_DATA_W : geometry of the 1M x 16 board SRAM
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RECOVER
  } state_t;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } grant_t;

endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Sole owner of every board SRAM pin, shared between the recorder (write
// port) and the player (read port). Each access is IDLE -> WRITE/READ for
// WAIT_CYCLES cycles -> one RECOVER cycle carrying the ack, so peak
// throughput is one access per WAIT_CYCLES+2 cycles. Ties alternate.
//
// Ports
//   i_clk, i_rst          : BCLK and asynchronous active-high reset
//   i_wr_req/addr/data    : write request (level, held until o_wr_ack)
//   o_wr_ack              : one-cycle pulse, write completed
//   i_rd_req/addr         : read request (level, held until o_rd_ack)
//   o_rd_data, o_rd_ack   : last read word and its one-cycle update pulse
//   o_sram_*              : SRAM address, data bus and active-low strobes
//   o_busy                : high whenever an access is in flight
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n,
  output logic              o_busy
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              dq_oe_q, dq_oe_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;

  // Next-state logic. Strobes, drive-enable and acks are all computed one
  // cycle ahead so every pin comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dq_oe_d      = dq_oe_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    rd_data_d    = rd_data_q;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_wr_req || i_rd_req) begin
          cnt_d = 4'd0;
          // On a tie the port not served last wins.
          if (i_wr_req && (!i_rd_req || last_grant_q == GNT_RD)) begin
            last_grant_d = GNT_WR;
            addr_d       = i_wr_addr;
            wdata_d      = i_wr_data;
            dq_oe_d      = 1'b1;
            we_n_d       = 1'b0;
            state_d      = S_WRITE;
          end else begin
            last_grant_d = GNT_RD;
            addr_d       = i_rd_addr;
            dq_oe_d      = 1'b0;
            oe_n_d       = 1'b0;
            state_d      = S_READ;
          end
        end
      end

      S_WRITE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = 4'd0;
          we_n_d   = 1'b1;
          wr_ack_d = 1'b1;
          state_d  = S_RECOVER;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_READ: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = 4'd0;
          oe_n_d    = 1'b1;
          rd_data_d = io_sram_dq;
          rd_ack_d  = 1'b1;
          state_d   = S_RECOVER;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_RECOVER: begin
        // Write data was held through this cycle for SRAM hold time.
        dq_oe_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any access in flight without an ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_RD;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dq_oe_q      <= 1'b0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      rd_data_q    <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dq_oe_q      <= dq_oe_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      rd_data_q    <= rd_data_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
    end
  end

  assign io_sram_dq  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_sram_addr = addr_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_ce_n = 1'b0;
  assign o_sram_ub_n = 1'b0;
  assign o_sram_lb_n = 1'b0;
  assign o_rd_data   = rd_data_q;
  assign o_wr_ack    = wr_ack_q;
  assign o_rd_ack    = rd_ack_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Bench for sram_arbiter. A transaction-level reference model watches the
// request levels at each clock edge, decides grants by the round-robin rule
// and pushes the expected access (port, address, data, grant edge) into a
// queue. A monitor on the falling edge pops the queue as accesses finish and
// checks every SRAM pin, ack and o_rd_data against it. A second instance
// with WAIT_CYCLES = 1 gets a short directed write.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int W       = 2;
  localparam int W1      = 1;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        wr_req = 1'b0;
  logic [19:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [19:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
  logic        busy;

  logic        d1_wr_req = 1'b0;
  logic [19:0] d1_wr_addr = '0;
  logic [15:0] d1_wr_data = '0;
  logic        d1_wr_ack;
  logic [15:0] d1_rd_data;
  logic        d1_rd_ack;
  logic [19:0] d1_addr;
  wire  [15:0] d1_dq;
  logic        d1_we_n, d1_oe_n, d1_ce_n, d1_ub_n, d1_lb_n, d1_busy;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_ack(rd_ack),
    .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
    .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n),
    .o_sram_ce_n(sram_ce_n), .o_sram_ub_n(sram_ub_n), .o_sram_lb_n(sram_lb_n),
    .o_busy(busy)
  );

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W1)) u_dut_w1 (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(d1_wr_req), .i_wr_addr(d1_wr_addr), .i_wr_data(d1_wr_data), .o_wr_ack(d1_wr_ack),
    .i_rd_req(1'b0), .i_rd_addr(20'h0), .o_rd_data(d1_rd_data), .o_rd_ack(d1_rd_ack),
    .o_sram_addr(d1_addr), .io_sram_dq(d1_dq),
    .o_sram_we_n(d1_we_n), .o_sram_oe_n(d1_oe_n),
    .o_sram_ce_n(d1_ce_n), .o_sram_ub_n(d1_ub_n), .o_sram_lb_n(d1_lb_n),
    .o_busy(d1_busy)
  );

  // SRAM device model: 256 words are enough for the addresses used here.
  logic [15:0] sram_mem [0:255];
  assign sram_dq = (!sram_oe_n) ? sram_mem[sram_addr[7:0]] : 16'hzzzz;

  initial begin
    forever begin
      @(negedge clk);
      if (!sram_we_n) sram_mem[sram_addr[7:0]] = sram_dq;
    end
  end

  // Scoreboard and reference model state
  typedef struct {
    bit          is_wr;
    logic [19:0] addr;
    logic [15:0] data;
    int          g;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] ref_mem [0:255];
  int          cyc = 0;
  int          free_edge = 0;
  bit          last_was_wr = 1'b0;
  bit          order_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one access at a time, next grant possible WAIT+2 edges
  // after the previous one; ties go to the port not served last.
  initial begin : ref_model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        free_edge   = 0;
        last_was_wr = 1'b0;
      end else begin
        cyc++;
        if (cyc >= free_edge && (wr_req || rd_req)) begin
          txn_t t;
          t.is_wr = wr_req && (!rd_req || !last_was_wr);
          t.g     = cyc;
          if (t.is_wr) begin
            t.addr = wr_addr;
            t.data = wr_data;
            ref_mem[wr_addr[7:0]] = wr_data;
          end else begin
            t.addr = rd_addr;
            t.data = ref_mem[rd_addr[7:0]];
          end
          last_was_wr = t.is_wr;
          free_edge   = cyc + W + 2;
          exp_q.push_back(t);
        end
      end
    end
  end

  // Monitor: compares the main instance's pins every cycle against the
  // access at the head of the scoreboard, retiring it on its ack cycle.
  initial begin : monitor
    txn_t        t;
    bit          active;
    logic        e_we, e_oe, e_busy, e_wack, e_rack;
    logic [15:0] exp_rd;
    exp_rd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_rd = '0;
      end else begin
        active = 1'b0;
        e_we = 1'b1; e_oe = 1'b1; e_busy = 1'b0; e_wack = 1'b0; e_rack = 1'b0;
        if (exp_q.size() > 0) begin
          t = exp_q[0];
          if (cyc >= t.g && cyc <= t.g + W) active = 1'b1;
        end
        if (active) begin
          e_busy = 1'b1;
          if (cyc < t.g + W) begin
            if (t.is_wr) e_we = 1'b0;
            else         e_oe = 1'b0;
          end else begin
            if (t.is_wr) e_wack = 1'b1;
            else         e_rack = 1'b1;
          end
        end
        checkOutput("busy",   32'(busy),      32'(e_busy));
        checkOutput("we_n",   32'(sram_we_n), 32'(e_we));
        checkOutput("oe_n",   32'(sram_oe_n), 32'(e_oe));
        checkOutput("wr_ack", 32'(wr_ack),    32'(e_wack));
        checkOutput("rd_ack", 32'(rd_ack),    32'(e_rack));
        checkOutput("strobe_overlap", 32'(sram_we_n | sram_oe_n), 32'd1);
        checkOutput("ce_ub_lb", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
        if (active) begin
          checkOutput("sram_addr", 32'(sram_addr), 32'(t.addr));
          if (t.is_wr) checkOutput("sram_dq_write", 32'(sram_dq), 32'(t.data));
          if (cyc == t.g + W) begin
            if (!t.is_wr) exp_rd = t.data;
            void'(exp_q.pop_front());
          end
        end
        checkOutput("rd_data", 32'(rd_data), 32'(exp_rd));
      end
    end
  end

  // Requester tasks: raise req at a falling edge, wait for the ack pulse,
  // then either drop req or keep it high for the next access.
  task automatic wrOne(input logic [19:0] a, input logic [15:0] d, input bit drop);
    int waited = 0;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!wr_ack && waited < TIMEOUT);
    if (wr_ack) order_q.push_back(1'b1);
    else        checkOutput("wr_ack_timeout", 32'(wr_ack), 32'd1);
    if (drop || !wr_ack) wr_req = 1'b0;
  endtask

  task automatic rdOne(input logic [19:0] a, input bit drop, output int ack_cyc);
    int waited = 0;
    rd_addr = a;
    rd_req  = 1'b1;
    ack_cyc = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rd_ack && waited < TIMEOUT);
    if (rd_ack) begin
      order_q.push_back(1'b0);
      ack_cyc = cyc;
    end else begin
      checkOutput("rd_ack_timeout", 32'(rd_ack), 32'd1);
    end
    if (drop || !rd_ack) rd_req = 1'b0;
  endtask

  task automatic wrStream(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, max_gap);
      wrOne(20'($urandom_range(0, 15)), 16'($urandom), (gap > 0) || (i == n - 1));
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic rdStream(input int n, input bit seq, input int max_gap, input bit chk_spacing);
    int prev = 0;
    int now_c;
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, max_gap);
      logic [19:0] a = seq ? 20'(i) : 20'($urandom_range(0, 15));
      rdOne(a, (gap > 0) || (i == n - 1), now_c);
      if (chk_spacing && i > 0) checkOutput("b2b_ack_spacing", 32'(now_c - prev), 32'(W + 2));
      prev = now_c;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic applyStimulus_resetMidWrite();
    int waited = 0;
    wr_addr = 20'h80;
    wr_data = 16'h5555;
    wr_req  = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (sram_we_n && waited < TIMEOUT);
    checkOutput("midwr_we_low_seen", 32'(sram_we_n), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midwr_we_n_after_rst", 32'(sram_we_n), 32'd1);
    checkOutput("midwr_busy_after_rst", 32'(busy), 32'd0);
    checkOutput("midwr_ack_after_rst",  32'(wr_ack), 32'd0);
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("midwr_no_late_ack", 32'(wr_ack), 32'd0);
    end
  endtask

  task automatic applyStimulus_waitOne();
    int low_cnt = 0;
    int ack_at  = 0;
    @(negedge clk);
    d1_wr_addr = 20'h5;
    d1_wr_data = 16'hA5A5;
    d1_wr_req  = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      if (!d1_we_n) begin
        low_cnt++;
        checkOutput("w1_dq",   32'(d1_dq),   32'h0000A5A5);
        checkOutput("w1_addr", 32'(d1_addr), 32'h5);
      end
      if (d1_wr_ack && ack_at == 0) begin
        ack_at    = s;
        d1_wr_req = 1'b0;
      end
    end
    d1_wr_req = 1'b0;
    checkOutput("w1_we_low_cycles", 32'(low_cnt), 32'(W1));
    checkOutput("w1_ack_latency",   32'(ack_at),  32'(W1 + 1));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion expected $finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int  c;
    bit  ord[3];
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 16'(i * 257) ^ 16'h5A00;
      ref_mem[i]  = 16'(i * 257) ^ 16'h5A00;
    end
    sram_mem[16] = 16'h1234;
    ref_mem[16]  = 16'h1234;

    repeat (3) @(negedge clk);
    checkOutput("reset_we_n",    32'(sram_we_n), 32'd1);
    checkOutput("reset_oe_n",    32'(sram_oe_n), 32'd1);
    checkOutput("reset_busy",    32'(busy),      32'd0);
    checkOutput("reset_addr",    32'(sram_addr), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data),   32'd0);
    checkOutput("reset_acks",    32'({wr_ack, rd_ack}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] read of preloaded word");
    rdOne(20'h10, 1'b1, c);
    checkOutput("read_only_data", 32'(rd_data), 32'h1234);
    repeat (3) @(negedge clk);
    checkOutput("rd_data_held", 32'(rd_data), 32'h1234);

    $display("[TB] write then read back");
    wrOne(20'h10, 16'hBEEF, 1'b1);
    repeat (2) @(negedge clk);
    rdOne(20'h10, 1'b1, c);
    checkOutput("readback_data", 32'(rd_data), 32'hBEEF);

    $display("[TB] reset in the middle of a write");
    applyStimulus_resetMidWrite();

    $display("[TB] tie after reset");
    order_q.delete();
    fork
      begin
        wrOne(20'h20, 16'h1111, 1'b0);
        wrOne(20'h21, 16'h2222, 1'b1);
      end
      rdOne(20'h20, 1'b1, c);
    join
    checkOutput("tie_count", 32'(order_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) ord[i] = (order_q.size() > i) ? order_q[i] : 1'b0;
    checkOutput("tie_order", 32'({ord[0], ord[1], ord[2]}), 32'b101);
    checkOutput("tie_read_data", 32'(rd_data), 32'h1111);

    $display("[TB] back-to-back reads");
    repeat (2) @(negedge clk);
    rdStream(8, 1'b1, 0, 1'b1);

    $display("[TB] random concurrent traffic");
    repeat (2) @(negedge clk);
    fork
      wrStream(20, 3);
      rdStream(20, 1'b0, 3, 1'b0);
    join
    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] WAIT_CYCLES=1 instance");
    applyStimulus_waitOne();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port 1M x 16 board SRAM between two requesters: the recorder (write port) and the player (read port).
- Replaces the bare address mux and the split WE_N/OE_N/DQ ownership at top level with one owner of every SRAM pin.
- Uses a req/ack handshake, round-robin arbitration on ties, fixed strobe timing and a bus-recovery cycle.
- Sits between the recorder/player and the SRAM pins, clocked by BCLK.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, cycles the WE_N/OE_N strobe is held low per access; legal range 1..15.

Ports:
- i_clk  in  1  system clock (BCLK domain).
- i_rst  in  1  asynchronous, active-high reset.
- i_wr_req  in  1  write request; level, held until o_wr_ack.
- i_wr_addr  in  ADDR_W  write address; stable while i_wr_req high.
- i_wr_data  in  DATA_W  write data; stable while i_wr_req high.
- o_wr_ack  out  1  one-cycle pulse: write completed.
- i_rd_req  in  1  read request; level, held until o_rd_ack.
- i_rd_addr  in  ADDR_W  read address; stable while i_rd_req high.
- o_rd_data  out  DATA_W  last read word; valid from the o_rd_ack cycle until the next read completes.
- o_rd_ack  out  1  one-cycle pulse: o_rd_data updated.
- o_sram_addr  out  ADDR_W  SRAM address.
- io_sram_dq  inout  DATA_W  SRAM data bus.
- o_sram_we_n, o_sram_oe_n  out  1 each  SRAM strobes, active low.
- o_sram_ce_n, o_sram_ub_n, o_sram_lb_n  out  1 each  constant 0.
- o_busy  out  1  high whenever state != S_IDLE.

Behaviour:
- Reset values (immediate on i_rst, also mid-access):
  - State S_IDLE, last_grant = RD.
  - o_sram_we_n = 1, o_sram_oe_n = 1, io_sram_dq high-Z.
  - o_sram_addr = 0, o_rd_data = 0, o_wr_ack = 0, o_rd_ack = 0, o_busy = 0, cnt = 0.
  - An interrupted access is abandoned and never acked.
- States: S_IDLE, S_WRITE, S_READ, S_RECOVER. All SRAM pins and acks are driven from registers (no combinational path from req to pins).
- S_IDLE arbitration at each edge:
  - Only one req high: grant it.
  - Both high: grant the port opposite last_grant. After reset, the first tie goes to WR.
  - On grant: latch address (and write data), set last_grant, cnt = 0, go to S_WRITE or S_READ.
  - Neither high: stay in S_IDLE.
- S_WRITE:
  - o_sram_addr and DQ driven with latched values; o_sram_we_n = 0; o_sram_oe_n = 1.
  - Lasts exactly WAIT_CYCLES cycles (cnt 0..WAIT_CYCLES-1), then go to S_RECOVER.
- S_READ:
  - o_sram_addr driven; o_sram_oe_n = 0; DQ high-Z.
  - Lasts WAIT_CYCLES cycles. At the edge leaving the last cycle, capture io_sram_dq into o_rd_data, then go to S_RECOVER.
- S_RECOVER (exactly 1 cycle):
  - Both strobes high; address held.
  - After a write, DQ stays driven (hold time); after a read, DQ stays Z.
  - Ack of the served port = 1 for this cycle only; then go to S_IDLE.
- Latency: req sampled at edge k → strobe low cycles k+1..k+WAIT_CYCLES → ack in cycle k+WAIT_CYCLES+1. That is 4 cycles per access at default, including the IDLE cycle; peak throughput is 1 access per WAIT_CYCLES+2 cycles.
- Handshake rule: a requester must drop req by the edge that ends its ack cycle. A req still high in the following S_IDLE counts as a new request.
- Requests arriving while busy wait in S_IDLE arbitration; none are lost, since req is level.
- Changing addr/data while req is high: undefined for the requester, but the arbiter uses only the values latched at grant.
- Never are both strobes low together; DQ is never driven while o_sram_oe_n = 0.

Decomposition:
- Package sram_arb_pkg:
  - state enum {S_IDLE, S_WRITE, S_READ, S_RECOVER}.
  - grant enum {GNT_WR, GNT_RD}.
  - Constants SRAM_ADDR_W = 20 and SRAM_DATA_W = 16.
- Single module, no sub-module. The tristate is one continuous assign on a registered drive-enable.

Test Plan:
- Write only: wr_req with addr 0x00010, data 0xBEEF → we_n low cycles 1–2, DQ = 0xBEEF, addr = 0x00010, wr_ack in cycle 3, o_busy high cycles 1–3.
- Read only: SRAM model returns 0x1234 at 0x00010 → oe_n low 2 cycles, DQ Z, rd_ack in cycle 3 with o_rd_data = 0x1234, held through later idle cycles.
- Tie after reset: both req high, held through three accesses → grant order WR, RD, WR; acks alternate; strobes never overlap.
- Reset mid-write: assert i_rst during the second we_n-low cycle → we_n = 1 and DQ Z immediately, no wr_ack; after release, the next wr_req completes normally.
- Back-to-back: rd_req held high for 8 accesses with no writer → rd_ack every 4 cycles, addresses 0..7 stepped by the requester after each ack.
- WAIT_CYCLES = 1: single write → we_n low exactly 1 cycle, wr_ack 2 cycles after the grant edge.
